// File: rtl/uart_pkg.sv
// +----------------------------------------------------------------------+
// | uart_pkg : shared types, frame constants and baud divider helpers    |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
`default_nettype none

package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BRK   = 3'd4
  } rx_state_t;

  localparam int c_data_bits = 8;
  localparam int c_stop_bits = 1;

  // Bit period in clock cycles, rounded to nearest.
  function automatic int calc_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

  function automatic int calc_half(input int div);
    return div / 2;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// +----------------------------------------------------------------------+
// | sync_fifo : first-word-fall-through FIFO, push+pop allowed when full |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
`default_nettype none

module sync_fifo #(
  parameter int AW = 4,
  parameter int W  = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [W-1:0]  i_data,
  output logic [W-1:0]  o_data,
  output logic          o_empty,
  output logic          o_full,
  output logic [AW:0]   o_count,
  output logic          o_overrun
);

  localparam logic [AW:0] c_depth = {1'b1, {AW{1'b0}}};

  logic [W-1:0]  r_mem [2**AW];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0]   r_count;
  logic          r_ovr;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_wr;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == c_depth);
  assign w_pop   = i_pop && !w_empty;
  // On full, a same-cycle pop frees the slot the write pointer aliases.
  assign w_wr    = i_push && (!w_full || w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
      r_ovr   <= 1'b0;
    end else begin
      if (w_wr)  r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_ovr <= i_push && w_full && !w_pop;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wp] <= i_data;
  end

  assign o_data    = w_empty ? '0 : r_mem[r_rp];
  assign o_empty   = w_empty;
  assign o_full    = w_full;
  assign o_count   = r_count;
  assign o_overrun = r_ovr;

endmodule

`default_nettype wire

// File: rtl/uart_rx_fifo.sv
// +----------------------------------------------------------------------+
// | uart_rx_fifo : 8N1 UART receiver feeding a FWFT byte FIFO            |
// | Option macro : UART_RX_MAJORITY_EN (2-of-3 majority bit sampling)    |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
`default_nettype none

module uart_rx_fifo #(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115200,
  parameter int AW     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_rx_i,
  input  logic        rd_en_i,
  output logic [7:0]  data_o,
  output logic        empty_o,
  output logic        full_o,
  output logic [AW:0] count_o,
  output logic        frame_err_o,
  output logic        overrun_o
);

  import uart_pkg::*;

  localparam int c_div  = calc_div(CLK_HZ, BAUD);
  localparam int c_half = calc_half(c_div);
  localparam int c_cw   = $clog2(c_div);
  localparam int c_iw   = $clog2(c_data_bits);
`ifdef UART_RX_MAJORITY_EN
  localparam int c_skew = 1;
`else
  localparam int c_skew = 0;
`endif
  localparam logic [c_cw-1:0] c_start_last = c_cw'(c_half - 1 + c_skew);
  localparam logic [c_cw-1:0] c_bit_last   = c_cw'(c_div - 1);
  localparam logic [c_iw-1:0] c_idx_last   = c_iw'(c_data_bits - 1);

  rx_state_t              r_state;
  rx_state_t              w_state_nxt;
  logic [1:0]             r_sync;
  logic [c_cw-1:0]        r_cnt;
  logic [c_iw-1:0]        r_idx;
  logic [c_data_bits-1:0] r_shift;
  logic                   r_push;
  logic                   r_ferr;

  logic w_rxs;
  logic w_bit;
  logic w_tick_start;
  logic w_tick_bit;
  logic w_cnt_clr;
  logic w_shift_en;
  logic w_push;
  logic w_ferr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sync <= 2'b11;
    else     r_sync <= {r_sync[0], uart_rx_i};
  end
  assign w_rxs = r_sync[1];

`ifdef UART_RX_MAJORITY_EN
  // Decision lands one cycle late so the sample after the instant is visible.
  logic [1:0] r_hist;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_hist <= 2'b11;
    else     r_hist <= {r_hist[0], w_rxs};
  end
  assign w_bit = (r_hist[1] & r_hist[0]) | (r_hist[1] & w_rxs) | (r_hist[0] & w_rxs);
`else
  assign w_bit = w_rxs;
`endif

  assign w_tick_start = (r_cnt == c_start_last);
  assign w_tick_bit   = (r_cnt == c_bit_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_clr   = 1'b0;
    w_shift_en  = 1'b0;
    w_push      = 1'b0;
    w_ferr      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_rxs) begin
          w_state_nxt = S_START;
          w_cnt_clr   = 1'b1;
        end
      end
      S_START: begin
        if (w_tick_start) begin
          w_cnt_clr   = 1'b1;
          w_state_nxt = w_bit ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (w_tick_bit) begin
          w_cnt_clr  = 1'b1;
          w_shift_en = 1'b1;
          if (r_idx == c_idx_last) w_state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (w_tick_bit) begin
          w_cnt_clr = 1'b1;
          if (w_bit) begin
            w_push      = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_ferr      = 1'b1;
            w_state_nxt = S_BRK;
          end
        end
      end
      S_BRK: begin
        if (w_rxs) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_push  <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      if (w_cnt_clr)
        r_cnt <= '0;
      else if (r_state != S_IDLE && r_state != S_BRK)
        r_cnt <= r_cnt + 1'b1;
      if (r_state == S_START)
        r_idx <= '0;
      else if (w_shift_en)
        r_idx <= r_idx + 1'b1;
      if (w_shift_en)
        r_shift <= {w_bit, r_shift[c_data_bits-1:1]};
      r_push <= w_push;
      r_ferr <= w_ferr;
    end
  end

  assign frame_err_o = r_ferr;

  sync_fifo #(
    .AW (AW),
    .W  (c_data_bits)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_push    (r_push),
    .i_pop     (rd_en_i),
    .i_data    (r_shift),
    .o_data    (data_o),
    .o_empty   (empty_o),
    .o_full    (full_o),
    .o_count   (count_o),
    .o_overrun (overrun_o)
  );

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
// +----------------------------------------------------------------------+
// | tb_uart_rx_fifo : directed serial frames against a queue-based model |
// | Revision        : 1.0                                                |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_uart_rx_fifo;

  localparam int CLK_HZ = 50_000_000;
  localparam int BAUD   = 3_125_000;
  localparam int AW     = 4;
  localparam int DEPTH  = 16;
  localparam int DIV    = 16;
  localparam int HALF   = 8;
`ifdef UART_RX_MAJORITY_EN
  localparam int SKEW = 1;
`else
  localparam int SKEW = 0;
`endif
  // Edges from the first edge that sees a falling line to the stop decision.
  localparam int LAT = 2 + HALF + 9 * DIV + SKEW;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        uart_rx_i = 1'b1;
  logic        rd_en_i = 1'b0;
  logic [7:0]  data_o;
  logic        empty_o;
  logic        full_o;
  logic [AW:0] count_o;
  logic        frame_err_o;
  logic        overrun_o;

  uart_rx_fifo #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD),
    .AW     (AW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .uart_rx_i   (uart_rx_i),
    .rd_en_i     (rd_en_i),
    .data_o      (data_o),
    .empty_o     (empty_o),
    .full_o      (full_o),
    .count_o     (count_o),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o)
  );

  always #10 clk = ~clk;

  typedef struct {
    int         at_cyc;
    logic [7:0] data;
  } ev_t;

  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  int         n_ferr = 0;
  int         n_ovr = 0;
  bit         cmp_en = 1'b0;
  logic [7:0] mq[$];
  ev_t        ev_q[$];
  int         ferr_q[$];
  bit         m_ferr = 1'b0;
  bit         m_ovr = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: byte queue updated on each edge by pop-then-push rules.
  initial begin
    logic [7:0] b;
    forever begin
      @(posedge clk);
      cyc++;
      m_ferr = 1'b0;
      m_ovr  = 1'b0;
      if (rst) begin
        mq.delete();
        ev_q.delete();
        ferr_q.delete();
      end else begin
        if (rd_en_i && mq.size() > 0) void'(mq.pop_front());
        if (ev_q.size() > 0 && ev_q[0].at_cyc == cyc) begin
          b = ev_q[0].data;
          void'(ev_q.pop_front());
          if (mq.size() < DEPTH) mq.push_back(b);
          else                   m_ovr = 1'b1;
        end
        if (ferr_q.size() > 0 && ferr_q[0] == cyc) begin
          void'(ferr_q.pop_front());
          m_ferr = 1'b1;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (frame_err_o) n_ferr++;
        if (overrun_o)   n_ovr++;
        if (cmp_en) begin
          chk("empty", empty_o, (mq.size() == 0));
          chk("full", full_o, (mq.size() == DEPTH));
          chk("count", count_o, mq.size());
          if (mq.size() > 0) chk("data", data_o, mq[0]);
          chk("frame_err", frame_err_o, m_ferr);
          chk("overrun", overrun_o, m_ovr);
        end
      end
    end
  end

  task automatic send_frame(input logic [7:0] b);
    logic [9:0] bits;
    bits = {1'b1, b, 1'b0};
    ev_q.push_back('{at_cyc: cyc + 1 + LAT + 1, data: b});
    for (int i = 0; i < 10; i++) begin
      uart_rx_i = bits[i];
      repeat (DIV) @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain(input int n);
    rd_en_i = 1'b1;
    repeat (n) @(negedge clk);
    rd_en_i = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_data"}, data_o, 8'h00);
    chk({tag, "_empty"}, empty_o, 1'b1);
    chk({tag, "_full"}, full_o, 1'b0);
    chk({tag, "_count"}, count_o, 0);
    chk({tag, "_ferr"}, frame_err_o, 1'b0);
    chk({tag, "_ovr"}, overrun_o, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(4);
    chk_reset_vals("rst0");
    @(posedge clk); #3 rst = 1'b0;
    @(negedge clk);
    cmp_en = 1'b1;
    idle(5);

    // Single byte.
    send_frame(8'h55);
    idle(4);
    chk("pin_55_data", data_o, 8'h55);
    chk("pin_55_count", count_o, 1);
    drain(1);
    idle(3);

    // Back-to-back frames.
    send_frame(8'h00);
    send_frame(8'hFF);
    send_frame(8'hA3);
    idle(4);
    chk("pin_b2b_count", count_o, 3);
    chk("pin_b2b_head", data_o, 8'h00);
    drain(5);
    chk("pin_b2b_empty", count_o, 0);

    // Short low glitch on the idle line.
    uart_rx_i = 1'b0;
    idle(3);
    uart_rx_i = 1'b1;
    idle(40);
    chk("pin_glitch_count", count_o, 0);

    // Break: line low for two frame times.
    n_ferr = 0;
    ferr_q.push_back(cyc + 1 + LAT);
    uart_rx_i = 1'b0;
    idle(20 * DIV);
    uart_rx_i = 1'b1;
    idle(2 * DIV);
    chk("pin_brk_ferr", n_ferr, 1);
    chk("pin_brk_count", count_o, 0);
    send_frame(8'h5A);
    idle(4);
    chk("pin_5a_data", data_o, 8'h5A);
    drain(2);

    // 17 pushes without reads.
    n_ovr = 0;
    for (int i = 1; i <= 17; i++) send_frame(8'(8'h30 + i));
    idle(4);
    chk("pin_ovr_full", full_o, 1'b1);
    chk("pin_ovr_pulses", n_ovr, 1);
    chk("pin_ovr_head", data_o, 8'h31);
    drain(18);

    // 17th push coincides with a pop.
    n_ovr = 0;
    for (int i = 1; i <= 16; i++) send_frame(8'(8'h80 + i));
    fork
      send_frame(8'h91);
      begin
        repeat (LAT) @(negedge clk);
        rd_en_i = 1'b1;
        @(negedge clk);
        rd_en_i = 1'b0;
      end
    join
    idle(4);
    chk("pin_pp_ovr", n_ovr, 0);
    chk("pin_pp_count", count_o, 16);
    chk("pin_pp_head", data_o, 8'h82);
    drain(18);

    // Reset in the middle of a frame with bytes queued.
    for (int i = 0; i < 8; i++) send_frame(8'(8'hC0 + i));
    uart_rx_i = 1'b0;
    idle(DIV);
    uart_rx_i = 1'b1;
    idle(DIV);
    uart_rx_i = 1'b0;
    idle(DIV / 2);
    @(posedge clk); #3 rst = 1'b1;
    @(negedge clk);
    uart_rx_i = 1'b1;
    idle(2);
    chk_reset_vals("rst1");
    @(posedge clk); #3 rst = 1'b0;
    idle(3);
    send_frame(8'h3C);
    idle(4);
    chk("pin_3c_count", count_o, 1);
    chk("pin_3c_data", data_o, 8'h3C);
    drain(2);
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
